counter_monitor: RTL

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/counter_monitor.sv
// counter_monitor
//   Samples a free-running 2-bit ripple counter that is asynchronous to clk.
//   The raw value is synchronised and debounced; the filtered copy is then
//   tracked step by step. Clean +1 steps extend the count to EXT_W bits, and
//   any other step latches an error flag. An optional seven-segment decode
//   of the filtered value is built only when COUNTER_MONITOR_SEG_EN is
//   defined. Otherwise seg is tied to all-segments-off.
//
// Parameters
//   STABLE_CYCLES  consecutive identical synchronised samples (1..15) that
//                  are needed before a new value is accepted
//   EXT_W          width of the extended event count
//
// Ports
//   clk         in   single clock. All state changes on its rising edge.
//   clrn        in   asynchronous active-low reset
//   cnt_in[1:0] in   ripple-counter value {Q1,Q0}. It can glitch.
//   clr_ext     in   synchronous clear of ext_cnt/step_err. Also forces TRACK.
//   cnt_q[1:0]  out  filtered clk-domain copy of cnt_in (registered)
//   ext_cnt     out  count of accepted +1 steps, modulo 2^EXT_W (registered)
//   wrap_pulse  out  one-cycle pulse on an accepted 3->0 step (registered)
//   step_err    out  sticky flag: an accepted step other than +1 (registered)
//   seg[6:0]    out  active-low seven-segment pattern {g..a} of cnt_q
module counter_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int EXT_W         = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [1:0]       cnt_in,
  input  logic             clr_ext,
  output logic [1:0]       cnt_q,
  output logic [EXT_W-1:0] ext_cnt,
  output logic             wrap_pulse,
  output logic             step_err,
  output logic [6:0]       seg
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       s1_q, s2_q;
  logic [3:0]       stab_q, stab_d;
  logic [1:0]       cnt_d;
  logic [EXT_W-1:0] ext_d;
  logic             wrap_d, err_d;

  logic             accept;
  logic [1:0]       delta;
  logic             step_ok, step_bad;

  // stab_q counts how many clk samples s2_q has held its current value.
  // The count starts at 1 on the edge that loads a new value into s2_q. It
  // saturates at STAB_MAX, so a long-stable value stays eligible.
  always_comb begin
    stab_d = stab_q;
    if (s1_q != s2_q)
      stab_d = 4'd1;
    else if (stab_q != STAB_MAX)
      stab_d = stab_q + 4'd1;
  end

  // In INIT, even a value equal to the reset cnt_q counts as the first acceptance.
  assign accept   = (stab_q == STAB_MAX) && ((state_q == INIT) || (s2_q != cnt_q));
  assign delta    = s2_q - cnt_q;
  assign step_ok  = accept && (state_q == TRACK) && (delta == 2'd1);
  assign step_bad = accept && (state_q == TRACK) && delta[1];

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr_ext) begin
      state_d = TRACK;
    end else begin
      unique case (state_q)
        INIT:    if (accept)   state_d = TRACK;
        TRACK:   if (step_bad) state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  // Output next values. clr_ext overrides any counting in the same cycle.
  // cnt_q still follows the acceptance.
  always_comb begin
    cnt_d  = accept ? s2_q : cnt_q;
    ext_d  = ext_cnt;
    err_d  = step_err;
    wrap_d = 1'b0;
    if (clr_ext) begin
      ext_d = '0;
      err_d = 1'b0;
    end else begin
      if (step_ok) begin
        ext_d  = ext_cnt + EXT_W'(1);
        wrap_d = (cnt_q == 2'd3);
      end
      if (step_bad) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_q       <= 2'd0;
      s2_q       <= 2'd0;
      stab_q     <= 4'd0;
      cnt_q      <= 2'd0;
      ext_cnt    <= '0;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      s1_q       <= cnt_in;
      s2_q       <= s1_q;
      stab_q     <= stab_d;
      cnt_q      <= cnt_d;
      ext_cnt    <= ext_d;
      wrap_pulse <= wrap_d;
      step_err   <= err_d;
    end
  end

`ifdef COUNTER_MONITOR_SEG_EN
  always_comb begin
    seg = 7'b1111111;
    unique case (cnt_q)
      2'd0:    seg = 7'b1000000;
      2'd1:    seg = 7'b1111001;
      2'd2:    seg = 7'b0100100;
      default: seg = 7'b0110000;
    endcase
  end
`else
  assign seg = 7'b1111111;
`endif

endmodule
